// File: rtl/hazard_pkg.sv
// Shared constants and helpers for the hazard scoreboard: forward encoding and the
// flat layout of one scoreboard entry {ready, rd, v}.
package hazard_pkg;
  localparam int FWD_RF     = 0;
  localparam int POS_W      = 8;
  localparam int ENT_V      = 0;
  localparam int ENT_RD_LSB = 1;

  function automatic int ent_w(input int rw);
    return 1 + rw + POS_W;
  endfunction

  function automatic int ent_rdy_lsb(input int rw);
    return 1 + rw;
  endfunction

  // Position j maps to pipeline register STAGES-j on the EX operand muxes.
  function automatic int fwd_encode(input int stages, input int j);
    return stages - j;
  endfunction
endpackage

// File: rtl/hazard_scoreboard_if.sv
// ID-stage request and pipeline-control response bundle for the hazard scoreboard.
// HAZARD_ID_FWD_EN adds the ID branch-comparator forward selects.
interface hazard_scoreboard_if #(
  parameter int RW = 5,
  parameter int FW = 2
);
  logic          id_valid;
  logic [RW-1:0] id_rs;
  logic [RW-1:0] id_rt;
  logic          id_use_rs;
  logic          id_use_rt;
  logic          id_wr_en;
  logic [RW-1:0] id_rd;
  logic          id_is_load;
  logic          id_is_branch;
  logic          branch_taken;
  logic          pc_load;
  logic          ifid_ld;
  logic          sel_signal;
  logic          flush;
  logic [FW-1:0] fwd_a;
  logic [FW-1:0] fwd_b;
  logic [15:0]   stall_count;
`ifdef HAZARD_ID_FWD_EN
  logic [FW-1:0] id_fwd_a;
  logic [FW-1:0] id_fwd_b;

  modport master (
    output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_wr_en, id_rd,
           id_is_load, id_is_branch, branch_taken,
    input  pc_load, ifid_ld, sel_signal, flush, fwd_a, fwd_b, stall_count,
           id_fwd_a, id_fwd_b
  );
  modport slave (
    input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_wr_en, id_rd,
           id_is_load, id_is_branch, branch_taken,
    output pc_load, ifid_ld, sel_signal, flush, fwd_a, fwd_b, stall_count,
           id_fwd_a, id_fwd_b
  );
`else
  modport master (
    output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_wr_en, id_rd,
           id_is_load, id_is_branch, branch_taken,
    input  pc_load, ifid_ld, sel_signal, flush, fwd_a, fwd_b, stall_count
  );
  modport slave (
    input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_wr_en, id_rd,
           id_is_load, id_is_branch, branch_taken,
    output pc_load, ifid_ld, sel_signal, flush, fwd_a, fwd_b, stall_count
  );
`endif
endinterface

// File: rtl/hazard_src_sel.sv
// Priority matcher for one source operand: finds the youngest valid writer of src
// among positions 1..STAGES-1 and reports its position and ready position.
module hazard_src_sel
  import hazard_pkg::*;
#(
  parameter int RW     = 5,
  parameter int STAGES = 3
) (
  input  logic [STAGES:1][ent_w(RW)-1:0] ent,
  input  logic [RW-1:0]                  src,
  input  logic                           use_src,
  output logic                           hit,
  output logic [POS_W-1:0]               pos,
  output logic [POS_W-1:0]               rdy
);
  localparam int RDY_LSB = ent_rdy_lsb(RW);

  // Scan oldest-to-youngest so the smallest j overwrites; entry STAGES is RF-served.
  always_comb begin
    hit = 1'b0;
    pos = '0;
    rdy = '0;
    if (use_src && src != '0) begin
      for (int j = STAGES - 1; j >= 1; j--) begin
        if (ent[j][ENT_V] && ent[j][ENT_RD_LSB +: RW] == src) begin
          hit = 1'b1;
          pos = POS_W'(j);
          rdy = ent[j][RDY_LSB +: POS_W];
        end
      end
    end
  end
endmodule

// File: rtl/hazard_scoreboard.sv
// Parametrised hazard/forwarding controller for an N-stage MIPS pipeline.
// Define HAZARD_ID_FWD_EN to forward into the ID branch comparator instead of stalling.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int RW         = 5,
  parameter int STAGES     = 3,
  parameter int ALU_READY  = 2,
  parameter int LOAD_READY = 3,
  parameter int FW         = $clog2(STAGES)
) (
  input logic                 clk,
  input logic                 rst,
  hazard_scoreboard_if.slave  bus
);
  localparam int EW      = ent_w(RW);
  localparam int RDY_LSB = ent_rdy_lsb(RW);

  logic [STAGES:1][EW-1:0] ent_reg;
  logic [STAGES:1][EW-1:0] ent_next;
  logic [EW-1:0]           new_ent;
  logic [15:0]             stall_count_reg;
  logic                    stall;
  logic                    active;
  logic                    hit_a, hit_b;
  logic [POS_W-1:0]        pos_a, pos_b, rdy_a, rdy_b;
  logic                    ex_haz_a, ex_haz_b, br_haz;
  logic [FW-1:0]           enc_a, enc_b;

  // A stalled ID instruction enters EX as a bubble; older entries always advance.
  always_comb begin
    new_ent                    = '0;
    new_ent[ENT_V]             = bus.id_valid & bus.id_wr_en & (bus.id_rd != '0) & ~stall;
    new_ent[ENT_RD_LSB +: RW]  = bus.id_rd;
    new_ent[RDY_LSB +: POS_W]  = bus.id_is_load ? POS_W'(LOAD_READY) : POS_W'(ALU_READY);
  end

  assign ent_next[1] = new_ent;
  generate
    for (genvar gi = 2; gi <= STAGES; gi++) begin : g_shift
      assign ent_next[gi] = ent_reg[gi-1];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ent_reg <= '0;
    else      ent_reg <= ent_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                    stall_count_reg <= '0;
    else if (stall && stall_count_reg != 16'hFFFF) stall_count_reg <= stall_count_reg + 16'd1;
  end

  hazard_src_sel #(.RW(RW), .STAGES(STAGES)) u_sel_a (
    .ent(ent_reg), .src(bus.id_rs), .use_src(bus.id_use_rs),
    .hit(hit_a), .pos(pos_a), .rdy(rdy_a)
  );
  hazard_src_sel #(.RW(RW), .STAGES(STAGES)) u_sel_b (
    .ent(ent_reg), .src(bus.id_rt), .use_src(bus.id_use_rt),
    .hit(hit_b), .pos(pos_b), .rdy(rdy_b)
  );

  // Outputs are qualified by rst so they read idle immediately while reset is held.
  assign active   = rst & bus.id_valid;
  assign ex_haz_a = hit_a && (int'(pos_a) + 1 < int'(rdy_a));
  assign ex_haz_b = hit_b && (int'(pos_b) + 1 < int'(rdy_b));
  assign enc_a    = FW'(fwd_encode(STAGES, int'(pos_a)));
  assign enc_b    = FW'(fwd_encode(STAGES, int'(pos_b)));

`ifdef HAZARD_ID_FWD_EN
  logic late_a, late_b;
  assign late_a       = hit_a && (int'(pos_a) < int'(rdy_a));
  assign late_b       = hit_b && (int'(pos_b) < int'(rdy_b));
  assign br_haz       = bus.id_is_branch & (late_a | late_b);
  assign bus.id_fwd_a = (active && hit_a && !late_a) ? enc_a : FW'(FWD_RF);
  assign bus.id_fwd_b = (active && hit_b && !late_b) ? enc_b : FW'(FWD_RF);
`else
  assign br_haz = bus.id_is_branch & (hit_a | hit_b);
`endif

  assign stall           = active & (ex_haz_a | ex_haz_b | br_haz);
  assign bus.pc_load     = ~stall;
  assign bus.ifid_ld     = ~stall;
  assign bus.sel_signal  = ~stall;
  assign bus.flush       = active & bus.id_is_branch & bus.branch_taken & ~stall;
  assign bus.fwd_a       = (active && !stall && hit_a) ? enc_a : FW'(FWD_RF);
  assign bus.fwd_b       = (active && !stall && hit_b) ? enc_b : FW'(FWD_RF);
  assign bus.stall_count = stall_count_reg;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: default 3-stage instance for forwarding and
// hazards, plus a deep 16-stage instance to saturate stall_count quickly.
module tb_hazard_scoreboard;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  hazard_scoreboard_if #(.RW(5), .FW(2)) bus ();
  hazard_scoreboard #(.RW(5), .STAGES(3), .ALU_READY(2), .LOAD_READY(3), .FW(2)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave)
  );

  hazard_scoreboard_if #(.RW(5), .FW(4)) bus2 ();
  hazard_scoreboard #(.RW(5), .STAGES(16), .ALU_READY(2), .LOAD_READY(16), .FW(4)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2.slave)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic ctl(input string tag, input logic exp_stall);
    chk({tag, " pc_load"},    32'(bus.pc_load),    32'(!exp_stall));
    chk({tag, " ifid_ld"},    32'(bus.ifid_ld),    32'(!exp_stall));
    chk({tag, " sel_signal"}, 32'(bus.sel_signal), 32'(!exp_stall));
  endtask

  task automatic idle();
    bus.id_valid = 1'b0; bus.id_rs = '0; bus.id_rt = '0;
    bus.id_use_rs = 1'b0; bus.id_use_rt = 1'b0; bus.id_wr_en = 1'b0;
    bus.id_rd = '0; bus.id_is_load = 1'b0; bus.id_is_branch = 1'b0;
    bus.branch_taken = 1'b0;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
    idle();
  endtask

  initial begin
    idle();
    bus2.id_valid = 1'b0; bus2.id_rs = '0; bus2.id_rt = '0;
    bus2.id_use_rs = 1'b0; bus2.id_use_rt = 1'b0; bus2.id_wr_en = 1'b0;
    bus2.id_rd = '0; bus2.id_is_load = 1'b0; bus2.id_is_branch = 1'b0;
    bus2.branch_taken = 1'b0;

    // Reset held with garbage on every ID input
    bus.id_valid = 1'b1; bus.id_rs = 5'd7; bus.id_rt = 5'd7;
    bus.id_use_rs = 1'b1; bus.id_use_rt = 1'b1; bus.id_wr_en = 1'b1;
    bus.id_rd = 5'd7; bus.id_is_load = 1'b1; bus.id_is_branch = 1'b1;
    bus.branch_taken = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    ctl("reset", 1'b0);
    chk("reset flush",       32'(bus.flush),       0);
    chk("reset fwd_a",       32'(bus.fwd_a),       0);
    chk("reset fwd_b",       32'(bus.fwd_b),       0);
    chk("reset stall_count", 32'(bus.stall_count), 0);
    idle();
    @(negedge clk);
    rst = 1'b1;

    // ALU producer r8, then two consumers one and two cycles later
    next(); bus.id_valid = 1; bus.id_wr_en = 1; bus.id_rd = 5'd8; #1;
    ctl("add r8", 1'b0);
    next(); bus.id_valid = 1; bus.id_rs = 5'd8; bus.id_use_rs = 1;
    bus.id_wr_en = 1; bus.id_rd = 5'd10; #1;
    ctl("use rs=8 j1", 1'b0);
    chk("use rs=8 j1 fwd_a", 32'(bus.fwd_a), 2);
    next(); bus.id_valid = 1; bus.id_rt = 5'd8; bus.id_use_rt = 1; #1;
    chk("use rt=8 j2 fwd_b", 32'(bus.fwd_b), 1);
    chk("use rt=8 j2 fwd_a", 32'(bus.fwd_a), 0);

    // Load-use: one bubble, then forward from position 2
    next(); bus.id_valid = 1; bus.id_wr_en = 1; bus.id_rd = 5'd9; bus.id_is_load = 1; #1;
    ctl("lw r9", 1'b0);
    next(); bus.id_valid = 1; bus.id_rt = 5'd9; bus.id_use_rt = 1; #1;
    ctl("load-use stall", 1'b1);
    chk("load-use stall fwd_b", 32'(bus.fwd_b), 0);
    chk("load-use stall_count before", 32'(bus.stall_count), 0);
    @(posedge clk); #2;
    ctl("load-use resume", 1'b0);
    chk("load-use resume fwd_b", 32'(bus.fwd_b), 1);
    chk("load-use stall_count", 32'(bus.stall_count), 1);

    // Register 0 never matches; youngest of two r8 writers wins
    next(); bus.id_valid = 1; bus.id_wr_en = 1; bus.id_rd = 5'd0; #1;
    next(); bus.id_valid = 1; bus.id_rs = 5'd0; bus.id_use_rs = 1;
    bus.id_wr_en = 1; bus.id_rd = 5'd8; #1;
    ctl("use r0", 1'b0);
    chk("use r0 fwd_a", 32'(bus.fwd_a), 0);
    next(); bus.id_valid = 1; bus.id_wr_en = 1; bus.id_rd = 5'd8; #1;
    next(); bus.id_valid = 1; bus.id_rs = 5'd8; bus.id_use_rs = 1; #1;
    ctl("youngest r8", 1'b0);
    chk("youngest r8 fwd_a", 32'(bus.fwd_a), 2);

    // ALU producer r4 feeding a taken beq
    next(); bus.id_valid = 1; bus.id_wr_en = 1; bus.id_rd = 5'd4; #1;
    next(); bus.id_valid = 1; bus.id_rs = 5'd4; bus.id_use_rs = 1;
    bus.id_is_branch = 1; bus.branch_taken = 1; #1;
    ctl("beq c1", 1'b1);
    chk("beq c1 flush", 32'(bus.flush), 0);
`ifdef HAZARD_ID_FWD_EN
    @(posedge clk); #2;
    ctl("beq c2", 1'b0);
    chk("beq c2 id_fwd_a", 32'(bus.id_fwd_a), 1);
    chk("beq c2 flush", 32'(bus.flush), 1);
    chk("beq stall_count", 32'(bus.stall_count), 2);
`else
    @(posedge clk); #2;
    ctl("beq c2", 1'b1);
    chk("beq c2 flush", 32'(bus.flush), 0);
    @(posedge clk); #2;
    ctl("beq c3", 1'b0);
    chk("beq c3 flush", 32'(bus.flush), 1);
    chk("beq stall_count", 32'(bus.stall_count), 3);
`endif
    next(); #1;
    chk("after beq flush", 32'(bus.flush), 0);

    // Deep instance: a self-dependent load stalls 14 of every 15 cycles
    bus2.id_valid = 1; bus2.id_wr_en = 1; bus2.id_rd = 5'd9; bus2.id_is_load = 1;
    bus2.id_rs = 5'd9; bus2.id_use_rs = 1;
    repeat (70400) @(posedge clk);
    #2;
    chk("saturate stall_count", 32'(bus2.stall_count), 32'h0000FFFF);
    for (int i = 0; i < 20 && bus2.pc_load; i++) begin
      @(posedge clk); #2;
    end
    chk("deep stalled pc_load", 32'(bus2.pc_load), 0);
    chk("hold stall_count", 32'(bus2.stall_count), 32'h0000FFFF);
    rst = 1'b0;
    #1;
    chk("mid-stall reset stall_count", 32'(bus2.stall_count), 0);
    chk("mid-stall reset pc_load", 32'(bus2.pc_load), 1);
    #1;
    rst = 1'b1;
    #1;
    chk("after reset release pc_load", 32'(bus2.pc_load), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
